// File: rtl/minirv_dmem_responder.sv
// Data-memory responder for the miniRV CPU: word RAM with byte-lane writes plus an
// MMIO block (console TX FIFO, status, cycle counter, halt/exit latch).
module minirv_dmem_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [7:0]  exit_code
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    REG_CONSOLE_TX = 2'd0,
    REG_STATUS     = 2'd1,
    REG_CYCLE      = 2'd2,
    REG_HALT       = 2'd3
  } mmio_reg_e;

  logic [31:0] r_mem  [MEM_WORDS];
  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic        r_overflow;
  logic [31:0] r_cycle;
  logic        r_halted;
  logic [7:0]  r_exit_code;

  logic          w_sel_mmio;
  mmio_reg_e     w_reg;
  logic [AW-1:0] w_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_mmio_wr;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_halt_wr;
  logic          w_unused;

  assign w_sel_mmio = (dmem_addr[31:28] == 4'h1);
  assign w_reg      = mmio_reg_e'(dmem_addr[3:2]);
  assign w_idx      = dmem_addr[AW+1:2];
  assign w_unused   = ^{dmem_addr, dmem_wstrb[3:1]};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  assign w_mmio_wr  = w_sel_mmio && dmem_we && dmem_wstrb[0];
  assign w_push_req = w_mmio_wr && (w_reg == REG_CONSOLE_TX);
  assign w_pop      = !w_empty && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_mmio_wr && (w_reg == REG_STATUS) && dmem_wdata[2];
  assign w_halt_wr  = w_mmio_wr && (w_reg == REG_HALT) && !r_halted;

  always_ff @(posedge clk) begin
    if (dmem_we && !w_sel_mmio) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dmem_wstrb[i]) r_mem[w_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= dmem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_cycle     <= '0;
      r_halted    <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
      if (w_halt_wr) begin
        r_halted    <= 1'b1;
        r_exit_code <= dmem_wdata[7:0];
      end
    end
  end

  always_comb begin
    dmem_rdata = '0;
    if (w_sel_mmio) begin
      case (w_reg)
        REG_CONSOLE_TX: dmem_rdata = '0;
        REG_STATUS:     dmem_rdata = {29'b0, r_overflow, w_full, w_empty};
        REG_CYCLE:      dmem_rdata = r_cycle;
        REG_HALT:       dmem_rdata = {23'b0, r_halted, r_exit_code};
        default:        dmem_rdata = '0;
      endcase
    end else begin
      dmem_rdata = r_mem[w_idx];
    end
  end

  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? '0 : r_fifo[r_rptr[PW-1:0]];
  assign halted    = r_halted;
  assign exit_code = r_exit_code;

endmodule

// File: tb/tb_minirv_dmem_responder.sv
// Directed + randomized bench for minirv_dmem_responder against a queue/array model
// of the memory map.
module tb_minirv_dmem_responder;
  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic [7:0]  exit_code;

  minirv_dmem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halted(halted), .exit_code(exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: memory map seen as plain storage and a byte queue.
  logic [31:0] m_mem [int unsigned];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [31:0] m_cycle;
  logic        m_halt;
  logic [7:0]  m_exit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_cycle = '0;
    m_halt  = 1'b0;
    m_exit  = '0;
  endtask

  task automatic exp_rdata(output logic [31:0] v, output bit ok);
    int unsigned key;
    ok = 1'b1;
    v  = '0;
    if (dmem_addr[31:28] == 4'h1) begin
      case (dmem_addr[3:2])
        2'd0: v = 32'd0;
        2'd1: v = {29'd0, m_ovf, (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
        2'd2: v = m_cycle;
        default: v = {23'd0, m_halt, m_exit};
      endcase
    end else begin
      key = (dmem_addr >> 2) % MEM_WORDS;
      if (m_mem.exists(key)) v = m_mem[key];
      else ok = 1'b0;
    end
  endtask

  task automatic model_update();
    bit mmio, pop, wr0, push, set;
    int unsigned key;
    logic [31:0] w;
    mmio = (dmem_addr[31:28] == 4'h1);
    pop  = (m_q.size() > 0) && tx_ready;
    wr0  = mmio && dmem_we && dmem_wstrb[0];
    push = 1'b0;
    set  = 1'b0;
    if (wr0 && dmem_addr[3:2] == 2'd0) begin
      if (m_q.size() < FIFO_DEPTH || pop) push = 1'b1;
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (wr0 && dmem_addr[3:2] == 2'd1 && dmem_wdata[2]) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(dmem_wdata[7:0]);
    if (wr0 && dmem_addr[3:2] == 2'd3 && !m_halt) begin
      m_halt = 1'b1;
      m_exit = dmem_wdata[7:0];
    end
    if (!mmio && dmem_we) begin
      key = (dmem_addr >> 2) % MEM_WORDS;
      w = m_mem.exists(key) ? m_mem[key] : 32'hxxxx_xxxx;
      for (int i = 0; i < 4; i++) if (dmem_wstrb[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
      m_mem[key] = w;
    end
    m_cycle = m_cycle + 32'd1;
  endtask

  // One bus cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic [31:0] a, input logic we, input logic [3:0] st,
                      input logic [31:0] wd, input logic rdy);
    logic [31:0] ev;
    bit ok;
    dmem_addr = a; dmem_we = we; dmem_wstrb = st; dmem_wdata = wd; tx_ready = rdy;
    @(negedge clk);
    exp_rdata(ev, ok);
    if (ok) chk("rdata", dmem_rdata, ev);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, (m_q.size() > 0)});
    chk("tx_data", {24'd0, tx_data}, {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("exit_code", {24'd0, exit_code}, {24'd0, m_exit});
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a);
    dmem_addr = a; dmem_we = 1'b0;
    #1;
  endtask

  task automatic rand_phase(input int n, input bit allow_halt);
    logic [31:0] a, wd;
    logic [3:0]  st;
    logic        we, rdy;
    int unsigned kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 6);
      wd   = $urandom;
      st   = 4'($urandom);
      we   = 1'($urandom);
      rdy  = ($urandom_range(0, 2) != 0);
      a    = 32'h1000_0000 | ($urandom & 32'h0FFF_FFF3);
      case (kind)
        0, 1, 2: begin
          a = ($urandom & 32'hEFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
          if (kind == 2) we = 1'b0;
        end
        3: a[3:2] = 2'd0;
        4: a[3:2] = 2'd1;
        5: a[3:2] = 2'd2;
        default: begin
          a[3:2] = 2'd3;
          if (!allow_halt || $urandom_range(0, 7) != 0) we = 1'b0;
        end
      endcase
      step(a, we, st, wd, rdy);
    end
  endtask

  logic [31:0] c1, c2;

  initial begin
    rst_n = 1'b0; dmem_addr = '0; dmem_we = 1'b0; dmem_wstrb = '0; dmem_wdata = '0; tx_ready = 1'b0;
    model_reset();
    #23;
    peek(32'h1000_0004);
    chk("rst_status", dmem_rdata, 32'h1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Known contents for the random RAM region.
    for (int i = 0; i < 16; i++) step(32'(i * 4), 1'b1, 4'hF, $urandom, 1'b0);

    // Byte-lane write and gated stores.
    step(32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0);
    step(32'h41, 1'b1, 4'b0010, 32'h0000_AB00, 1'b0);
    peek(32'h40); chk("ram_lane", dmem_rdata, 32'hDEAD_ABEF);
    step(32'h40, 1'b0, 4'hF, 32'h1234_5678, 1'b0);
    step(32'h41, 1'b0, 4'b0010, 32'h0000_FF00, 1'b0);
    peek(32'h40); chk("ram_no_we", dmem_rdata, 32'hDEAD_ABEF);
    peek(32'h4000_1040); chk("ram_alias", dmem_rdata, 32'hDEAD_ABEF);

    // Console stream.
    step(32'h1000_0000, 1'b1, 4'hF, 32'h48, 1'b0);
    chk("tx_lat_valid", {31'd0, tx_valid}, 32'd1);
    chk("tx_lat_data", {24'd0, tx_data}, 32'h48);
    step(32'h1000_0000, 1'b1, 4'hF, 32'h69, 1'b0);
    step(32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0);
    chk("tx_hold", {24'd0, tx_data}, 32'h48);
    step(32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b1);
    chk("tx_second", {24'd0, tx_data}, 32'h69);
    step(32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b1);
    chk("tx_drained", {31'd0, tx_valid}, 32'd0);
    peek(32'h1000_0004); chk("status_empty", dmem_rdata, 32'h1);

    // Overflow, full push-with-pop, W1C.
    for (int i = 0; i < 9; i++) step(32'h1000_0000, 1'b1, 4'h1, 32'(8'hA0 + i), 1'b0);
    peek(32'h1000_0004); chk("status_ovf", dmem_rdata, 32'h6);
    step(32'h1000_0000, 1'b1, 4'h1, 32'hAA, 1'b1);
    peek(32'h1000_0004); chk("status_full_pushpop", dmem_rdata, 32'h6);
    chk("head_after_pushpop", {24'd0, tx_data}, 32'hA1);
    step(32'h1000_0004, 1'b1, 4'h1, 32'h4, 1'b0);
    peek(32'h1000_0004); chk("status_w1c", dmem_rdata, 32'h2);
    for (int i = 0; i < 8; i++) step(32'h1000_0008, 1'b0, 4'h0, 32'h0, 1'b1);
    chk("drained_last", {31'd0, tx_valid}, 32'd0);

    // Cycle counter delta and wrap.
    peek(32'h1000_0008); c1 = dmem_rdata;
    for (int i = 0; i < 100; i++) step(32'h1000_0008, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
    peek(32'h1000_0008); c2 = dmem_rdata;
    chk("cycle_delta", c2 - c1, 32'd100);
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1 release dut.r_cycle;
    m_cycle = 32'hFFFF_FFFE;
    step(32'h1000_0008, 1'b0, 4'h0, 32'h0, 1'b0);
    step(32'h1000_0008, 1'b0, 4'h0, 32'h0, 1'b0);
    peek(32'h1000_0008); chk("cycle_wrap", dmem_rdata, 32'h0);

    rand_phase(300, 1'b0);
    for (int i = 0; i < 10; i++) step(32'h1000_0004, 1'b0, 4'h0, 32'h0, 1'b1);

    // Halt latch.
    step(32'h1000_000C, 1'b1, 4'h1, 32'h2A, 1'b0);
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("exit_set", {24'd0, exit_code}, 32'h2A);
    step(32'h1000_000C, 1'b1, 4'hF, 32'h07, 1'b0);
    peek(32'h1000_000C); chk("halt_read", dmem_rdata, 32'h12A);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) step(32'h1000_0000, 1'b1, 4'h1, 32'(8'h31 + i), 1'b0);
    chk("queued_before_rst", {31'd0, tx_valid}, 32'd1);
    peek(32'h1000_0008);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_exit", {24'd0, exit_code}, 32'd0);
    chk("arst_cycle", dmem_rdata, 32'd0);
    peek(32'h40); chk("arst_ram_kept", dmem_rdata, 32'hDEAD_ABEF);
    peek(32'h1000_0004); chk("arst_status", dmem_rdata, 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    rand_phase(150, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
